// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, branch unit states and the
// bit positions of the N, V and Z flags inside the 3-bit NVZ vector.
package cpu_pkg;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_UN = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } br_state_t;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/branch_unit_if.sv
// Branch unit bus: the branch issue inputs, the redirect handshake to fetch,
// and the status, flush and statistics outputs.
//   slave  : the branch unit side
//   master : the issuing pipeline / fetch side
interface branch_unit_if #(
    parameter int PC_W = 16
);
    logic            iValid;
    logic [2:0]      iCond;
    logic [2:0]      iNVZ;
    logic [PC_W-1:0] iTarget;
    logic            iRedirReady;
    logic            oBusy;
    logic            oResolved;
    logic            oTaken;
    logic            oRedirValid;
    logic [PC_W-1:0] oRedirPc;
    logic            oFlush;
    logic [15:0]     oBrCount;
    logic [15:0]     oTakenCount;

    modport slave (
        input  iValid, iCond, iNVZ, iTarget, iRedirReady,
        output oBusy, oResolved, oTaken, oRedirValid, oRedirPc, oFlush,
               oBrCount, oTakenCount
    );

    modport master (
        output iValid, iCond, iNVZ, iTarget, iRedirReady,
        input  oBusy, oResolved, oTaken, oRedirValid, oRedirPc, oFlush,
               oBrCount, oTakenCount
    );
endinterface

// File: rtl/branch_cond.sv
// Purely combinational branch condition evaluator.
// Ports:
//   iCond  - 3-bit condition code
//   iNVZ   - flags {N,V,Z}
//   oTaken - 1 when the condition holds
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] iCond,
    input  logic [2:0] iNVZ,
    output logic       oTaken
);
    logic w_n;
    logic w_v;
    logic w_z;

    assign w_n = iNVZ[FLAG_N];
    assign w_v = iNVZ[FLAG_V];
    assign w_z = iNVZ[FLAG_Z];

    always_comb begin
        oTaken = 1'b0;
        case (cond_t'(iCond))
            COND_NE: oTaken = ~w_z;
            COND_EQ: oTaken = w_z;
            COND_GT: oTaken = ~w_z & ~w_n;
            COND_LT: oTaken = w_n;
            COND_GE: oTaken = w_z | ~w_n;
            COND_LE: oTaken = w_n | w_z;
            COND_OV: oTaken = w_v;
            COND_UN: oTaken = 1'b1;
            default: oTaken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit. Evaluates a branch against the bypassed NVZ flags,
// issues a registered PC redirect to fetch over a valid/ready handshake for
// taken branches, then squashes the younger stages for SQUASH_CYCLES cycles.
// Keeps saturating counts of evaluated and taken branches.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - branch_unit_if slave: branch issue, redirect handshake,
//              busy/resolved/taken/flush status and statistics
module branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W          = 16,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    branch_unit_if.slave   bus
);
    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES - 1);

    br_state_t       r_state;
    br_state_t       w_state_next;
    logic [3:0]      r_sq_cnt;
    logic            r_resolved;
    logic            r_taken;
    logic [PC_W-1:0] r_redir_pc;
    logic [15:0]     r_br_count;
    logic [15:0]     r_taken_count;

    logic            w_accept;
    logic            w_cond_taken;
    logic            w_enter_squash;

    branch_cond u_cond (
        .iCond  (bus.iCond),
        .iNVZ   (bus.iNVZ),
        .oTaken (w_cond_taken)
    );

    assign w_accept       = bus.iValid && (r_state == IDLE);
    assign w_enter_squash = (r_state == REDIRECT) && bus.iRedirReady;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_cond_taken) w_state_next = REDIRECT;
            REDIRECT: if (bus.iRedirReady)          w_state_next = SQUASH;
            SQUASH:   if (r_sq_cnt == 4'd0)         w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter is loaded on the REDIRECT->SQUASH transition so that the
    // SQUASH state lasts exactly SQUASH_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq_cnt <= 4'd0;
        end else if (w_enter_squash) begin
            r_sq_cnt <= SQ_LOAD;
        end else if (r_state == SQUASH && r_sq_cnt != 4'd0) begin
            r_sq_cnt <= r_sq_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resolved    <= 1'b0;
            r_taken       <= 1'b0;
            r_redir_pc    <= '0;
            r_br_count    <= 16'd0;
            r_taken_count <= 16'd0;
        end else begin
            r_resolved <= w_accept;
            r_taken    <= w_accept && w_cond_taken;
            if (w_accept) begin
                if (r_br_count != 16'hFFFF) begin
                    r_br_count <= r_br_count + 16'd1;
                end
                if (w_cond_taken) begin
                    r_redir_pc <= bus.iTarget;
                    if (r_taken_count != 16'hFFFF) begin
                        r_taken_count <= r_taken_count + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.oBusy       = (r_state != IDLE);
    assign bus.oResolved   = r_resolved;
    assign bus.oTaken      = r_taken;
    assign bus.oRedirValid = (r_state == REDIRECT);
    assign bus.oRedirPc    = r_redir_pc;
    assign bus.oFlush      = (r_state == SQUASH);
    assign bus.oBrCount    = r_br_count;
    assign bus.oTakenCount = r_taken_count;

endmodule
